pmp_napot_encode: RTL and testbench

- Programming-side counterpart of the PMP NAPOT decode path. The decode path counts trailing ones in pmpaddr to recover region size. This block takes (base, log2 size, permissions) and builds the NAPOT/NA4 pmpaddr value plus the pmpcfg byte.
- It writes both into the PMP CSR file through a granted write port, then returns a status response.
- Sits between the M-mode PMP configuration agent (firmware helper / debug path) and the PMP CSR write mux.

---
 rtl/pmp_napot_pkg.sv | 43 ++++
 rtl/pmp_napot_encode_tmask.sv | 21 ++
 rtl/pmp_napot_encode.sv | 242 ++++++++++++++++++++++++
 tb/tb_pmp_napot_encode.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_napot_pkg.sv
// Shared types for the PMP NAPOT/NA4 programming path.
//   err_e     : status code returned with every response
//   pmp_a_e   : pmpcfg address-matching mode field
//   pmpcfg_t  : one pmpcfg byte, laid out MSB..LSB as {L, rsvd, A, X, W, R}
//   state_e   : encoder FSM states
package pmp_napot_pkg;

  localparam int PLEN_DEF       = 34;
  localparam int PMP_LEN_DEF    = 32;
  localparam int NR_ENTRIES_DEF = 8;

  typedef enum logic [1:0] {
    ERR_OK     = 2'd0,
    ERR_SIZE   = 2'd1,
    ERR_ALIGN  = 2'd2,
    ERR_LOCKED = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_a_e;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_WR_ADDR = 3'd2,
    ST_WR_CFG  = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/pmp_napot_encode_tmask.sv
// Count-to-trailing-ones mask: mask_o has its cnt_i least significant bits
// set and all others clear (cnt_i = W gives all ones). This is the inverse of
// the trailing-ones counter used on the PMP decode side.
//   cnt_i  : number of trailing ones, 0..W
//   mask_o : resulting W-bit mask
module pmp_tmask #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [CW-1:0] cnt_i,
  output logic [W-1:0]  mask_o
);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < W; i++) begin
      mask_o[i] = (CW'(i) < cnt_i);
    end
  end

endmodule

// File: rtl/pmp_napot_encode.sv
// Builds a NAPOT/NA4 pmpaddr value and the matching pmpcfg byte from
// (base, log2 size, permissions), writes both into the PMP CSR file through
// a granted write port (address first, then cfg), and returns a status.
//
// Handshakes: a request transfers on a cycle where req_valid_i and
// req_ready_o are both high; a CSR write completes on a cycle where csr_we_o
// and csr_gnt_i are both high; a response is consumed on a cycle where
// rsp_valid_o and rsp_ready_i are both high. Outputs of the producing side
// are held stable until the transfer.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_*                request channel (idx, base, log2 size k, {X,W,R}, L)
//   locked_i             current L bit of each entry
//   csr_we_o/csr_gnt_i   CSR write request / same-cycle grant
//   csr_sel_o            0 = pmpaddr write, 1 = pmpcfg byte write
//   csr_idx_o/wdata_o    entry index and write data (cfg uses [7:0])
//   rsp_valid_o/ready_i  response channel, rsp_err_o carries err_e
module pmp_napot_encode
  import pmp_napot_pkg::*;
#(
  parameter int PLEN       = PLEN_DEF,
  parameter int PMP_LEN    = PMP_LEN_DEF,
  parameter int NR_ENTRIES = NR_ENTRIES_DEF,
  parameter int IDX_W      = $clog2(NR_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [IDX_W-1:0]      req_idx_i,
  input  logic [PLEN-1:0]       req_base_i,
  input  logic [5:0]            req_log2size_i,
  input  logic [2:0]            req_perm_i,
  input  logic                  req_lock_i,
  input  logic [NR_ENTRIES-1:0] locked_i,
  output logic                  csr_we_o,
  input  logic                  csr_gnt_i,
  output logic                  csr_sel_o,
  output logic [IDX_W-1:0]      csr_idx_o,
  output logic [PMP_LEN-1:0]    csr_wdata_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_err_o
);

  localparam int         CNT_W = $clog2(PMP_LEN + 1);
  localparam logic [5:0] K_MAX = 6'(PLEN + 1);

  // State and registered request fields
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PLEN-1:0]      base_q, base_d;
  logic [5:0]           k_q, k_d;
  logic [2:0]           perm_q, perm_d;
  logic                 lock_q, lock_d;

  // Registered outputs
  logic                 req_ready_q, req_ready_d;
  logic                 csr_we_q, csr_we_d;
  logic                 csr_sel_q, csr_sel_d;
  logic [IDX_W-1:0]     csr_idx_q, csr_idx_d;
  logic [PMP_LEN-1:0]   csr_wdata_q, csr_wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  err_e                 rsp_err_q, rsp_err_d;

  // Encoding datapath
  logic [PMP_LEN-1:0]   base_w;
  logic [CNT_W-1:0]     ones_cnt;
  logic [PMP_LEN-1:0]   ones;
  logic [PMP_LEN-1:0]   align_mask;
  logic [PMP_LEN-1:0]   clr_bit;
  logic [PMP_LEN-1:0]   enc_addr;
  logic                 is_na4;
  logic                 size_err;
  logic                 align_err;
  pmpcfg_t              cfg;
  err_e                 chk_err;

  assign base_w = base_q[PLEN-1:2];

  // For NAPOT the fill is k-3 trailing ones; other k values never use it.
  always_comb begin
    ones_cnt = '0;
    if (k_q >= 6'd3 && k_q <= K_MAX) begin
      ones_cnt = CNT_W'(k_q - 6'd3);
    end
  end

  pmp_tmask #(
    .W  (PMP_LEN),
    .CW (CNT_W)
  ) u_tmask (
    .cnt_i  (ones_cnt),
    .mask_o (ones)
  );

  always_comb begin
    // One more trailing one covers base[k-1:2]; at full range it is all ones.
    align_mask = {ones[PMP_LEN-2:0], 1'b1};
    // Isolates bit k-3 (the NAPOT terminating zero); empty at full range.
    clr_bit    = ones ^ align_mask;
    is_na4     = (k_q == 6'd2);
    enc_addr   = is_na4 ? base_w : ((base_w & ~clr_bit) | ones);

    size_err   = (k_q < 6'd2) || (k_q > K_MAX);
    align_err  = 1'b0;
    if (k_q == 6'd2) begin
      align_err = (base_q[1:0] != 2'b00);
    end else if (k_q >= 6'd3) begin
      align_err = (base_q[1:0] != 2'b00) || ((base_w & align_mask) != '0);
    end

    if (locked_i[idx_q])  chk_err = ERR_LOCKED;
    else if (size_err)    chk_err = ERR_SIZE;
    else if (align_err)   chk_err = ERR_ALIGN;
    else                  chk_err = ERR_OK;

    cfg      = '0;
    cfg.l    = lock_q;
    cfg.rsvd = 2'b00;
    cfg.a    = is_na4 ? NA4 : NAPOT;
    cfg.x    = perm_q[2];
    cfg.w    = perm_q[1];
    cfg.r    = perm_q[0];
  end

  // Next-state and registered-output logic; every output holds by default.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    k_d         = k_q;
    perm_d      = perm_q;
    lock_d      = lock_q;
    req_ready_d = 1'b0;
    csr_we_d    = csr_we_q;
    csr_sel_d   = csr_sel_q;
    csr_idx_d   = csr_idx_q;
    csr_wdata_d = csr_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          idx_d       = req_idx_i;
          base_d      = req_base_i;
          k_d         = req_log2size_i;
          perm_d      = req_perm_i;
          lock_d      = req_lock_i;
          req_ready_d = 1'b0;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_err != ERR_OK) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = chk_err;
          state_d     = ST_RESP;
        end else begin
          csr_we_d    = 1'b1;
          csr_sel_d   = 1'b0;
          csr_idx_d   = idx_q;
          csr_wdata_d = enc_addr;
          state_d     = ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        if (csr_gnt_i) begin
          csr_sel_d   = 1'b1;
          csr_wdata_d = PMP_LEN'(cfg);
          state_d     = ST_WR_CFG;
        end
      end
      ST_WR_CFG: begin
        if (csr_gnt_i) begin
          csr_we_d    = 1'b0;
          csr_sel_d   = 1'b0;
          csr_idx_d   = '0;
          csr_wdata_d = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_OK;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = ERR_OK;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      k_q         <= '0;
      perm_q      <= '0;
      lock_q      <= 1'b0;
      req_ready_q <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_sel_q   <= 1'b0;
      csr_idx_q   <= '0;
      csr_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      k_q         <= k_d;
      perm_q      <= perm_d;
      lock_q      <= lock_d;
      req_ready_q <= req_ready_d;
      csr_we_q    <= csr_we_d;
      csr_sel_q   <= csr_sel_d;
      csr_idx_q   <= csr_idx_d;
      csr_wdata_q <= csr_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign csr_we_o    = csr_we_q;
  assign csr_sel_o   = csr_sel_q;
  assign csr_idx_o   = csr_idx_q;
  assign csr_wdata_o = csr_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_pmp_napot_encode.sv
// Bench for pmp_napot_encode: directed requests with hand-computed pmpaddr,
// cfg and status values; a negedge monitor matches every granted CSR write
// and every consumed response against expectation queues.
module tb_pmp_napot_encode;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_idx_i;
  logic [33:0] req_base_i;
  logic [5:0]  req_log2size_i;
  logic [2:0]  req_perm_i;
  logic        req_lock_i;
  logic [7:0]  locked_i;
  logic        csr_we_o;
  logic        csr_gnt_i;
  logic        csr_sel_o;
  logic [2:0]  csr_idx_o;
  logic [31:0] csr_wdata_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_err_o;

  pmp_napot_encode dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_idx_i      (req_idx_i),
    .req_base_i     (req_base_i),
    .req_log2size_i (req_log2size_i),
    .req_perm_i     (req_perm_i),
    .req_lock_i     (req_lock_i),
    .locked_i       (locked_i),
    .csr_we_o       (csr_we_o),
    .csr_gnt_i      (csr_gnt_i),
    .csr_sel_o      (csr_sel_o),
    .csr_idx_o      (csr_idx_o),
    .csr_wdata_o    (csr_wdata_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_err_o      (rsp_err_o)
  );

  // ---------------- scoreboard ----------------
  // write entry: {sel, idx, wdata}; response entry: {err, latency (0 = unchecked)}
  logic [35:0] exp_wr_q[$];
  logic [9:0]  exp_rsp_q[$];
  int chk_cnt    = 0;
  int pass_cnt   = 0;
  int cyc        = 0;
  int accept_cyc = 0;
  int rsp_cnt    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk_i) cyc++;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    logic [35:0] we;
    logic [9:0]  re;
    if (req_valid_i && req_ready_o) accept_cyc = cyc;
    if (csr_we_o && csr_gnt_i) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_csr_write", 64'd1, 64'd0);
      end else begin
        we = exp_wr_q.pop_front();
        check("csr_write", {csr_sel_o, csr_idx_o, csr_wdata_o}, we);
      end
    end
    if (rsp_valid_o && rsp_ready_i) begin
      rsp_cnt++;
      if (exp_rsp_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        re = exp_rsp_q.pop_front();
        check("rsp_err", rsp_err_o, re[9:8]);
        if (re[7:0] != 8'd0) check("rsp_latency", cyc - accept_cyc, re[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] idx, input logic [33:0] base, input logic [5:0] k,
                      input logic [2:0] perm, input logic lock);
    int n;
    @(posedge clk_i); #1;
    req_idx_i      = idx;
    req_base_i     = base;
    req_log2size_i = k;
    req_perm_i     = perm;
    req_lock_i     = lock;
    req_valid_i    = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      check("req_accept_timeout", 64'd0, 64'd1);
      req_valid_i = 1'b0;
    end else begin
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    if (rsp_cnt < target) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_we(input string name);
    int n;
    n = 0;
    while (!csr_we_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!csr_we_o) check(name, 64'd0, 64'd1);
  endtask

  task automatic run(input logic [2:0] idx, input logic [33:0] base, input logic [5:0] k,
                     input logic [2:0] perm, input logic lock, input logic [1:0] err,
                     input logic [31:0] addr, input logic [7:0] cfg, input logic [7:0] lat);
    int target;
    if (err == 2'd0) begin
      exp_wr_q.push_back({1'b0, idx, addr});
      exp_wr_q.push_back({1'b1, idx, 24'h0, cfg});
    end
    exp_rsp_q.push_back({err, lat});
    target = rsp_cnt + 1;
    send(idx, base, k, perm, lock);
    wait_rsp(target);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, req_ready_o, 64'd0);
    check({tag, "_csr_we"},    csr_we_o,    64'd0);
    check({tag, "_csr_sel"},   csr_sel_o,   64'd0);
    check({tag, "_csr_idx"},   csr_idx_o,   64'd0);
    check({tag, "_csr_wdata"}, csr_wdata_o, 64'd0);
    check({tag, "_rsp_valid"}, rsp_valid_o, 64'd0);
    check({tag, "_rsp_err"},   rsp_err_o,   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rsp_before;
    rst_ni = 1'b1;
    req_valid_i = 1'b0; req_idx_i = '0; req_base_i = '0; req_log2size_i = '0;
    req_perm_i = '0; req_lock_i = 1'b0; locked_i = '0;
    csr_gnt_i = 1'b1; rsp_ready_i = 1'b1;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check_outputs_zero("reset");
    rst_ni = 1'b1;

    // Successful encodings at minimum latency
    run(3'd2, 34'h0_8000_0000, 6'd12, 3'b011, 1'b0, 2'd0, 32'h2000_01FF, 8'h1B, 8'd4);
    run(3'd1, 34'h0_0000_1004, 6'd2,  3'b001, 1'b1, 2'd0, 32'h0000_0401, 8'h91, 8'd4);
    run(3'd0, 34'h0_0000_0000, 6'd35, 3'b111, 1'b0, 2'd0, 32'hFFFF_FFFF, 8'h1F, 8'd4);
    run(3'd6, 34'h0_0000_0010, 6'd3,  3'b100, 1'b0, 2'd0, 32'h0000_0004, 8'h1C, 8'd4);
    run(3'd7, 34'h0_0000_0000, 6'd34, 3'b010, 1'b1, 2'd0, 32'h7FFF_FFFF, 8'h9A, 8'd4);

    // Error cases: response two cycles after acceptance, no writes
    run(3'd0, 34'h0_0000_0000, 6'd36, 3'b111, 1'b0, 2'd1, 32'h0, 8'h0, 8'd2);
    run(3'd2, 34'h0_8000_0800, 6'd12, 3'b011, 1'b0, 2'd2, 32'h0, 8'h0, 8'd2);
    run(3'd5, 34'h0_0000_1002, 6'd2,  3'b001, 1'b0, 2'd2, 32'h0, 8'h0, 8'd2);
    run(3'd4, 34'h2_0000_0000, 6'd34, 3'b001, 1'b0, 2'd2, 32'h0, 8'h0, 8'd2);
    run(3'd3, 34'h0_0000_0000, 6'd1,  3'b001, 1'b0, 2'd1, 32'h0, 8'h0, 8'd2);
    run(3'd3, 34'h0_0000_0003, 6'd40, 3'b001, 1'b0, 2'd1, 32'h0, 8'h0, 8'd2);

    // Locked entry: LOCKED wins over SIZE; other entries unaffected
    locked_i = 8'h08;
    run(3'd3, 34'h0_8000_0000, 6'd12, 3'b011, 1'b0, 2'd3, 32'h0, 8'h0, 8'd2);
    run(3'd3, 34'h0_8000_0001, 6'd1,  3'b011, 1'b0, 2'd3, 32'h0, 8'h0, 8'd2);
    run(3'd2, 34'h0_8000_0000, 6'd12, 3'b011, 1'b0, 2'd0, 32'h2000_01FF, 8'h1B, 8'd4);
    locked_i = 8'h00;

    // Backpressure on the CSR port and on the response channel
    csr_gnt_i = 1'b0;
    exp_wr_q.push_back({1'b0, 3'd5, 32'h1000_1FFF});
    exp_wr_q.push_back({1'b1, 3'd5, 24'h0, 8'h1F});
    exp_rsp_q.push_back({2'd0, 8'd0});
    rsp_before = rsp_cnt;
    send(3'd5, 34'h0_4000_0000, 6'd16, 3'b111, 1'b0);
    wait_we("bp_we_timeout");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_we",    csr_we_o,    64'd1);
      check("bp_hold_sel",   csr_sel_o,   64'd0);
      check("bp_hold_idx",   csr_idx_o,   64'd5);
      check("bp_hold_wdata", csr_wdata_o, 64'h1000_1FFF);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    csr_gnt_i   = 1'b1;
    for (int n = 0; n < 20 && !rsp_valid_o; n++) @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      check("rsp_hold_valid", rsp_valid_o, 64'd1);
      check("rsp_hold_err",   rsp_err_o,   64'd0);
      check("rsp_hold_ready", req_ready_o, 64'd0);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    wait_rsp(rsp_before + 1);

    // Asynchronous reset while in WR_CFG; the address write already completed
    csr_gnt_i = 1'b0;
    exp_wr_q.push_back({1'b0, 3'd4, 32'h2000_01FF});
    rsp_before = rsp_cnt;
    send(3'd4, 34'h0_8000_0000, 6'd12, 3'b011, 1'b0);
    wait_we("rst_we_timeout");
    @(posedge clk_i); #1;
    csr_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    csr_gnt_i = 1'b0;
    @(negedge clk_i);
    check("rst_in_wr_cfg", {csr_we_o, csr_sel_o}, 64'd3);
    #1 rst_ni = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    check("rst_addr_write_done", exp_wr_q.size(), 64'd0);
    repeat (2) @(negedge clk_i);
    check("rst_no_rsp", rsp_cnt - rsp_before, 64'd0);
    rst_ni    = 1'b1;
    csr_gnt_i = 1'b1;

    // Next request after reset completes normally
    run(3'd4, 34'h0_8000_0000, 6'd12, 3'b011, 1'b0, 2'd0, 32'h2000_01FF, 8'h1B, 8'd4);

    repeat (5) @(negedge clk_i);
    check("wr_queue_drained",  exp_wr_q.size(),  64'd0);
    check("rsp_queue_drained", exp_rsp_q.size(), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
